pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 128, width of the datapath payload (PC, operands, immediate, register IDs).
REQ-002 SHALL provide parameter CTRL_W, default 10, width of the control payload (WB/M/EX fields, FP flag).
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  upstream beat present.
REQ-006 SHALL provide port in_ready  output  1  stage can accept a beat this cycle.
REQ-007 SHALL provide port in_ctrl  input  CTRL_W  upstream control payload.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream datapath payload.
REQ-009 SHALL provide port flush  input  1  synchronous kill of all held beats (branch/jump squash).
REQ-010 SHALL provide port out_valid  output  1  downstream beat present.
REQ-011 SHALL provide port out_ready  input  1  downstream accepts the beat.
REQ-012 SHALL provide port out_ctrl  output  CTRL_W  registered control payload.
REQ-013 SHALL provide port out_data  output  DATA_W  registered datapath payload.
REQ-014 SHALL provide port occupancy  output  2  count of held beats: 0, 1, or 2.

Function
REQ-015 SHALL accept a beat on a cycle with in_valid=1 and in_ready=1, and retire a beat on a cycle with out_valid=1 and out_ready=1.
REQ-016 SHALL present an accepted beat on out_* one cycle after acceptance when the main register is empty or is retiring in the same cycle.
REQ-017 SHALL preserve beat order; no beat SHALL be duplicated or lost except by flush.
REQ-018 SHALL drive out_ctrl to all-zero whenever out_valid=0, so a bubble never asserts write enables downstream.
REQ-019 SHALL hold out_data and out_ctrl stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_data to its last value while empty, with no toggling required.
REQ-021 SHALL, on flush=1, invalidate all held beats at the next edge: out_valid=0, occupancy=0, out_ctrl=0.
REQ-022 SHALL give flush priority over a simultaneous accept; a beat accepted in the flush cycle SHALL be discarded.
REQ-023 SHALL give flush priority over a simultaneous retire; the retire completes downstream in that cycle, and nothing SHALL remain afterwards.
REQ-024 SHALL, on a simultaneous accept and retire with occupancy=1, replace the main register with the new beat and leave occupancy at 1.
REQ-025 SHALL compute occupancy as the number of valid main and skid entries, with no wrap-around.

Reset
REQ-026 SHALL, while reset=1, force out_valid=0, occupancy=0, out_ctrl=0, out_data=0, and clear the skid entry, regardless of clk.
REQ-027 SHALL, on reset asserted mid-transfer, discard all beats; after reset deassertion, in_ready SHALL equal 1 in the first cycle.

Configuration
REQ-028 SHALL support macro PIPE_STAGE_SKID_EN.
REQ-029 SHALL, when PIPE_STAGE_SKID_EN is defined, include a one-entry skid register and drive in_ready as NOT skid_valid, a pure register output with no combinational path from out_ready; a beat accepted while the main register stalls SHALL go to the skid entry and move to the main register on the cycle after the main register retires.
REQ-030 SHALL, when PIPE_STAGE_SKID_EN is undefined, omit the skid entry and drive in_ready = out_ready OR NOT out_valid (combinational), so occupancy never exceeds 1.

Verification
REQ-031 SHALL cover this case: after reset, drive in_valid=1, in_data=0x...AB, in_ctrl=0x3FF, out_ready=1; out_valid=1 and out_data=0x...AB one cycle later, with occupancy=1.
REQ-032 SHALL cover this case (SKID_EN): hold out_ready=0 and push beats A and B; occupancy=2 and in_ready=0 with A on the outputs; then raise out_ready for 2 cycles; A then B retire in order, and occupancy returns to 0.
REQ-033 SHALL cover this case: flush=1 at occupancy=2 together with in_valid=1 carrying beat C; the next cycle shows out_valid=0, out_ctrl=0, occupancy=0, and C never appears on the outputs.
REQ-034 SHALL cover this case: with out_valid=0, drive in_ctrl=0x155 with in_valid=0; out_ctrl stays 0x000 for 5 cycles.
REQ-035 SHALL cover this case: assert reset asynchronously mid-cycle at occupancy=2; the outputs clear before the next clk edge, and in_ready=1 on the first cycle after release.
REQ-036 SHALL cover this case (no SKID_EN): set out_ready=0 at occupancy=1; in_ready=0 in the same cycle, occupancy stays 1, and toggling out_ready to 1 makes in_ready=1 combinationally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble-safe control.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              retire;

    assign accept = in_valid & in_ready;
    assign retire = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // in_ready comes straight from a flop, breaking the out_ready timing path
    assign in_ready = ~skid_valid;

    // While the skid is full nothing is accepted; it drains into main on retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (retire) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || retire) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
            end
        end else if (retire) begin
            main_valid <= 1'b0;
        end
    end

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
`else
    assign in_ready = out_ready | ~main_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
        end else if (retire) begin
            main_valid <= 1'b0;
        end
    end

    assign occupancy = {1'b0, main_valid};
`endif

    // Bubbles must never carry write enables downstream
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; a queue models the beats held by the stage.
// Builds with or without PIPE_STAGE_SKID_EN, matching the RTL configuration.
module tb_pipe_stage_reg;

    localparam int DW = 128;
    localparam int CW = 10;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    beat_t         q[$];
    logic [DW-1:0] last_data;
    int            checks;
    int            errors;

    localparam logic [DW-1:0] DATA_AB = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66AB;
    localparam logic [DW-1:0] DATA_A  = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
    localparam logic [DW-1:0] DATA_B  = 128'hBBBB_0000_1111_2222_3333_4444_5555_000B;
    localparam logic [DW-1:0] DATA_C  = 128'hCCCC_0000_1111_2222_3333_4444_5555_000C;
    localparam logic [DW-1:0] DATA_D  = 128'hDDDD_0000_1111_2222_3333_4444_5555_000D;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic exp_ready();
        if (SKID) return q.size() < 2;
        return out_ready || (q.size() == 0);
    endfunction

    function automatic logic [CW-1:0] exp_ctrl();
        if (q.size() == 0) return '0;
        return q[0].ctrl;
    endfunction

    // One clock of stimulus; the scoreboard advances using the bench's own readiness model
    task automatic drive_cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                               input logic ordy, input logic fl);
        logic  acc;
        logic  ret;
        beat_t b;
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        acc = iv && exp_ready();
        ret = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ret) b = q.pop_front();
            if (acc) begin
                b.ctrl = ic;
                b.data = id;
                q.push_back(b);
            end
        end
        if (q.size() > 0) last_data = q[0].data;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        q.delete();
        last_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("[TB] FAIL reset_ctrl got %h want 0", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", out_data); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        drive_cycle(1'b1, 10'h3FF, DATA_AB, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b want 1", out_valid); end
        checks++; if (out_data !== DATA_AB) begin errors++; $display("[TB] FAIL basic_data got %h want %h", out_data, DATA_AB); end
        checks++; if (out_ctrl !== 10'h3FF) begin errors++; $display("[TB] FAIL basic_ctrl got %h want 3ff", out_ctrl); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL basic_occ got %0d want 1", occupancy); end
        drive_cycle(1'b0, 10'h000, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain_valid got %b want 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("[TB] FAIL basic_drain_ctrl got %h want 0", out_ctrl); end
        checks++; if (out_data !== DATA_AB) begin errors++; $display("[TB] FAIL basic_drain_data got %h want %h", out_data, DATA_AB); end
    endtask

    task automatic test_stall();
        if (SKID) begin
            drive_cycle(1'b1, 10'h0A1, DATA_A, 1'b0, 1'b0);
            drive_cycle(1'b1, 10'h0B2, DATA_B, 1'b0, 1'b0);
            checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL skid_occ2 got %0d want 2", occupancy); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_ready got %b want 0", in_ready); end
            checks++; if (out_data !== DATA_A) begin errors++; $display("[TB] FAIL skid_head got %h want %h", out_data, DATA_A); end
            drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
            checks++; if (out_data !== DATA_B || out_ctrl !== 10'h0B2) begin errors++; $display("[TB] FAIL skid_second got %h/%h want %h/0b2", out_data, out_ctrl, DATA_B); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL skid_occ1 got %0d want 1", occupancy); end
            drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
            checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL skid_empty got occ %0d valid %b want 0 0", occupancy, out_valid); end
        end else begin
            drive_cycle(1'b1, 10'h0A1, DATA_A, 1'b0, 1'b0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready got %b want 0", in_ready); end
            drive_cycle(1'b1, 10'h0B2, DATA_B, 1'b0, 1'b0);
            checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL stall_occ got %0d want 1", occupancy); end
            checks++; if (out_data !== DATA_A || out_ctrl !== 10'h0A1) begin errors++; $display("[TB] FAIL stall_hold got %h/%h want %h/0a1", out_data, out_ctrl, DATA_A); end
            out_ready = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_comb_ready got %b want 1", in_ready); end
            drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %b want 0", out_valid); end
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 10'h011, DATA_A, 1'b0, 1'b0);
        drive_cycle(1'b1, 10'h022, DATA_B, 1'b0, 1'b0);
        checks++; if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin errors++; $display("[TB] FAIL flush_pre_occ got %0d want %0d", occupancy, SKID ? 2 : 1); end
        drive_cycle(1'b1, 10'h3CC, DATA_C, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("[TB] FAIL flush_ctrl got %h want 0", out_ctrl); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL flush_occ got %0d want 0", occupancy); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0 || out_data === DATA_C) begin errors++; $display("[TB] FAIL flush_ghost cyc %0d got valid %b data %h", i, out_valid, out_data); end
        end
    endtask

    task automatic test_bubble_ctrl();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 10'h155, DATA_D, i[0], 1'b0);
            checks++; if (out_ctrl !== 10'h000) begin errors++; $display("[TB] FAIL bubble_ctrl cyc %0d got %h want 000", i, out_ctrl); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int i = 0; i < 40; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive_cycle(1'($urandom_range(0, 3) != 0), 10'($urandom()), d, 1'($urandom_range(0, 2) != 0), 1'b0);
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("[TB] FAIL b2b_valid cyc %0d got %b want %b", i, out_valid, q.size() > 0); end
            checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("[TB] FAIL b2b_occ cyc %0d got %0d want %0d", i, occupancy, q.size()); end
            checks++; if (out_ctrl !== exp_ctrl()) begin errors++; $display("[TB] FAIL b2b_ctrl cyc %0d got %h want %h", i, out_ctrl, exp_ctrl()); end
            checks++; if (out_data !== last_data) begin errors++; $display("[TB] FAIL b2b_data cyc %0d got %h want %h", i, out_data, last_data); end
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("[TB] FAIL b2b_ready cyc %0d got %b want %b", i, in_ready, exp_ready()); end
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL b2b_drain got %0d want 0", occupancy); end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 10'h0AA, DATA_A, 1'b0, 1'b0);
        drive_cycle(1'b1, 10'h0BB, DATA_B, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL areset_state got valid %b occ %0d want 0 0", out_valid, occupancy); end
        checks++; if (out_ctrl !== '0 || out_data !== '0) begin errors++; $display("[TB] FAIL areset_payload got %h/%h want 0/0", out_ctrl, out_data); end
        q.delete();
        last_data = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready got %b want 1", in_ready); end
        drive_cycle(1'b1, 10'h0DD, DATA_D, 1'b1, 1'b0);
        checks++; if (out_data !== DATA_D || out_ctrl !== 10'h0DD) begin errors++; $display("[TB] FAIL areset_after got %h/%h want %h/0dd", out_data, out_ctrl, DATA_D); end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_bubble_ctrl();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
